// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, error bits.
// Optional macro LSU_BYTE_ENABLE_EN (see lsu_mem_ctrl) does not change this package.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Illegal size counts as misaligned so both land in the same error bit.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_ILL) ||
               (size == SZ_HALF && lo[0]) ||
               (size == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: load extract/extend and read-modify-write merge.
// Behaviour is independent of LSU_BYTE_ENABLE_EN.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_f;
    logic [15:0] half_f;

    always_comb begin
        byte_f     = word[{addr_lo, 3'b000} +: 8];
        half_f     = addr_lo[1] ? word[31:16] : word[15:0];
        load_data  = word;
        store_word = word;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{~is_unsigned & byte_f[7]}}, byte_f};
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{~is_unsigned & half_f[15]}}, half_f};
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            default: begin
                load_data  = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multicycle load/store unit in front of a word-only data RAM.
// Define LSU_BYTE_ENABLE_EN to add mem_be and skip the read phase of sub-word stores.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
`ifdef LSU_BYTE_ENABLE_EN
    output logic [3:0]        mem_be,
`endif
    output lsu_state_e        dbg_state
);

    // Handshake: a request is taken on the rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE. rsp_valid is a single-cycle pulse per request.

    lsu_state_e  state, state_nxt;
    logic        acc;
    logic [1:0]  req_err;
    logic        a_we;
    logic [1:0]  a_lo;
    logic [31:0] a_wdata;
    logic [1:0]  a_size;
    logic        a_uns;
    logic [1:0]  a_err;
    logic [31:0] rd_word;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign acc = req_valid && (state == ST_IDLE);

    always_comb begin
        req_err               = 2'b00;
        req_err[ERR_MISALIGN] = is_misaligned(req_size, req_addr[1:0]);
        req_err[ERR_RANGE]    = (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(MEM_WORDS));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            a_we     <= 1'b0;
            a_lo     <= 2'b00;
            a_wdata  <= 32'd0;
            a_size   <= SZ_BYTE;
            a_uns    <= 1'b0;
            a_err    <= 2'b00;
            rd_word  <= 32'd0;
            mem_addr <= 32'd0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                a_we    <= req_we;
                a_lo    <= req_addr[1:0];
                a_wdata <= req_wdata;
                a_size  <= req_size;
                a_uns   <= req_unsigned;
                a_err   <= req_err;
                // Erroring requests never touch the RAM, so the address bus keeps its old value.
                if (req_err == 2'b00)
                    mem_addr <= 32'({req_addr[ADDR_W-1:2], 2'b00});
            end
            if (state == ST_READ)
                rd_word <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err != 2'b00)        state_nxt = ST_RESP;
                    else if (!req_we)            state_nxt = ST_READ;
                    else if (req_size == SZ_WORD) state_nxt = ST_WRITE;
                    else
`ifdef LSU_BYTE_ENABLE_EN
                                                 state_nxt = ST_WRITE;
`else
                                                 state_nxt = ST_READ;
`endif
                end
            end
            ST_READ:  state_nxt = a_we ? ST_WRITE : ST_RESP;
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    lsu_lane_align u_align (
        .word        (rd_word),
        .wdata       (a_wdata),
        .addr_lo     (a_lo),
        .size        (a_size),
        .is_unsigned (a_uns),
        .load_data   (load_data),
        .store_word  (store_word)
    );

    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        mem_we    = (state == ST_WRITE);
        rsp_err   = rsp_valid ? a_err : 2'b00;
        rsp_rdata = (rsp_valid && !a_we && a_err == 2'b00) ? load_data : 32'd0;
        mem_wdata = 32'd0;
`ifdef LSU_BYTE_ENABLE_EN
        mem_be = 4'b0000;
        if (mem_we) begin
            case (a_size)
                SZ_BYTE: begin
                    mem_wdata = {4{a_wdata[7:0]}};
                    mem_be    = 4'b0001 << a_lo;
                end
                SZ_HALF: begin
                    mem_wdata = {2{a_wdata[15:0]}};
                    mem_be    = a_lo[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    mem_wdata = a_wdata;
                    mem_be    = 4'b1111;
                end
            endcase
        end
`else
        if (mem_we)
            mem_wdata = store_word;
`endif
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: RAM model, reference memory and response scoreboard.
// Build with LSU_BYTE_ENABLE_EN defined to exercise the byte-enable variant.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LSU_BYTE_ENABLE_EN
    logic [3:0]  mem_be;
`endif
    lsu_state_e  dbg_state;

    lsu_mem_ctrl #(.MEM_WORDS(64), .ADDR_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
`ifdef LSU_BYTE_ENABLE_EN
        .mem_be       (mem_be),
`endif
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read, word (or per-lane) write
    logic [31:0] ram     [0:63];
    logic [31:0] ref_mem [0:63];
    int we_cnt = 0;

    assign mem_rdata = ram[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
`ifdef LSU_BYTE_ENABLE_EN
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) ram[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
`else
            ram[mem_addr[7:2]] <= mem_wdata;
`endif
            we_cnt <= we_cnt + 1;
        end
    end

    // scoreboard
    logic [33:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    int total = 0;
    int bad   = 0;
    int exp_writes = 0;
    int exp_rsps   = 0;
    int rsp_cnt    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // Reference model: expected {err, rdata}, latency and whether a RAM write happens.
    task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic uns,
                         output logic [33:0] e, output int lat, output bit wr);
        logic [31:0] w;
        logic [7:0]  bf;
        logic [15:0] hf;
        logic        e0, e1;
        int          k;
        k  = int'(a[1:0]);
        e0 = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        e1 = (a[31:2] >= 30'd64);
        wr = 1'b0;
        if (e0 || e1) begin
            e   = {e1, e0, 32'd0};
            lat = 1;
        end else if (!we) begin
            w   = ref_mem[a[7:2]];
            lat = 2;
            case (sz)
                2'b00: begin
                    bf = w[8*k +: 8];
                    e  = {2'b00, (uns ? 24'd0 : {24{bf[7]}}), bf};
                end
                2'b01: begin
                    hf = a[1] ? w[31:16] : w[15:0];
                    e  = {2'b00, (uns ? 16'd0 : {16{hf[15]}}), hf};
                end
                default: e = {2'b00, w};
            endcase
        end else begin
            w  = ref_mem[a[7:2]];
            wr = 1'b1;
            e  = 34'd0;
            case (sz)
                2'b00: w[8*k +: 8] = wd[7:0];
                2'b01: w[16*(k/2) +: 16] = wd[15:0];
                default: w = wd;
            endcase
`ifdef LSU_BYTE_ENABLE_EN
            lat = 2;
`else
            lat = (sz == 2'b10) ? 2 : 3;
`endif
            ref_mem[a[7:2]] = w;
        end
    endtask

    // driver: leaves req_valid high so consecutive calls queue back-to-back
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input bit expect_rsp);
        logic [33:0] e;
        int          lat;
        bit          wr;
        int          g;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = uns;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("accept_timeout", 32'd0, 32'd1);
        if (expect_rsp) begin
            model(we, a, wd, sz, uns, e, lat, wr);
            exp_q.push_back(e);
            lat_q.push_back(lat);
            acc_q.push_back(cyc);
            exp_rsps++;
            if (wr) exp_writes++;
        end
        @(posedge clk);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // response monitor
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("rsp_extra", 32'd1, 32'd0);
            end else begin
                logic [33:0] e;
                int          l, a;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                a = acc_q.pop_front();
                check("rsp_rdata", rsp_rdata, e[31:0]);
                check("rsp_err", {30'd0, rsp_err}, {30'd0, e[33:32]});
                check("latency", 32'(cyc - a), 32'(l));
            end
        end
    end

    initial begin
        int w0;
        logic [31:0] saved;
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_size = 2'b00; req_unsigned = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ram[i]     = $urandom;
            ref_mem[i] = ram[i];
        end
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {30'd0, rsp_err}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // word store then signed byte load
        do_req(1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, 1'b1);
        do_req(1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b0, 1'b1);
        idle_bus();
        drain();
        check("t1_ram4", ram[4], 32'hDEADBEEF);

        // byte store read-modify-write, then unsigned half load
        w0 = we_cnt;
        do_req(1'b1, 32'h11, 32'h0000005A, SZ_BYTE, 1'b0, 1'b1);
        idle_bus();
        drain();
        check("t2_ram4", ram[4], 32'hDEAD5AEF);
        check("t2_one_write", 32'(we_cnt - w0), 32'd1);
        do_req(1'b0, 32'h12, 32'h0, SZ_HALF, 1'b1, 1'b1);
        idle_bus();
        drain();

        // misaligned / illegal size: no RAM writes
        w0 = we_cnt;
        do_req(1'b0, 32'h11, 32'h0, SZ_HALF, 1'b0, 1'b1);
        do_req(1'b1, 32'h0E, 32'h12345678, SZ_WORD, 1'b0, 1'b1);
        do_req(1'b0, 32'h20, 32'h0, SZ_ILL, 1'b0, 1'b1);
        idle_bus();
        drain();
        check("t3_no_write", 32'(we_cnt - w0), 32'd0);

        // out of range, alone and combined with misalignment
        do_req(1'b0, 32'h100, 32'h0, SZ_WORD, 1'b0, 1'b1);
        do_req(1'b0, 32'h101, 32'h0, SZ_HALF, 1'b0, 1'b1);
        idle_bus();
        drain();

        // reset during the read phase of a byte store
        w0    = we_cnt;
        saved = ram[6];
        do_req(1'b1, 32'h18, 32'h00000077, SZ_BYTE, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_mem_we", {31'd0, mem_we}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        check("abort_no_write", 32'(we_cnt - w0), 32'd0);
        check("abort_ram6", ram[6], saved);

        // back-to-back with req_valid held high
        do_req(1'b1, 32'h22, 32'h0000C3A5, SZ_HALF, 1'b0, 1'b1);
        do_req(1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, 1'b1);
        do_req(1'b0, 32'h21, 32'h0, SZ_BYTE, 1'b1, 1'b1);
        idle_bus();
        drain();

        // random mix, including some out-of-range and misaligned requests
        for (int n = 0; n < 30; n++) begin
            do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h10F)), $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 2) == 0) idle_bus();
        end
        idle_bus();
        drain();

        check("write_count", 32'(we_cnt), 32'(exp_writes));
        check("rsp_count", 32'(rsp_cnt), 32'(exp_rsps));
        for (int i = 0; i < 64; i++)
            check($sformatf("ram_%0d", i), ram[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
